score_display_scanner: RTL

//  Upstream feeder for the 7-segment decoder. Accepts a binary score, converts it
//  to BCD with a sequential double-dabble engine, and time-multiplexes the digits

---
 rtl/disp_pkg.sv | 21 ++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/score_display_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the score display path.
package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_t;

  // Largest decimal value representable in n digits (10^n - 1).
  function automatic int max_dec(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, result published
// on the edge that completes the final shift.
//
//  state    | meaning
//  CV_IDLE  | waiting for start
//  CV_SHIFT | add-3 then shift, VALUE_W cycles
//  CV_DONE  | result just published; a new start is accepted here too
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [VALUE_W-1:0]              bin,
  output logic                            done,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   bcd
);

  localparam int BCD_W = NUM_DIGITS * DIGIT_W;
  localparam int SR_W  = BCD_W + VALUE_W;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_W - 1);

  cv_state_t          state;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_next;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] nib;

  always_comb begin
    sr_adj = sr;
    nib    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib = sr[VALUE_W + DIGIT_W*k +: DIGIT_W];
      if (nib >= 4'd5) sr_adj[VALUE_W + DIGIT_W*k +: DIGIT_W] = nib + 4'd3;
    end
    sr_next = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Asserted during the cycle whose closing edge performs the last shift.
  assign done = (state == CV_SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CV_IDLE;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        CV_IDLE, CV_DONE: begin
          if (start) begin
            sr    <= {{BCD_W{1'b0}}, bin};
            cnt   <= '0;
            state <= CV_SHIFT;
          end else begin
            state <= CV_IDLE;
          end
        end
        CV_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            bcd   <= sr_next[SR_W-1 -: BCD_W];
            state <= CV_DONE;
          end
        end
        default: state <= CV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// Captures a binary score, converts it to BCD and scans the digits onto a
// shared digit bus with active-low anode enables.
module score_display_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = NUM_DIGITS * DIGIT_W;
  localparam int MAXD  = max_dec(NUM_DIGITS);
  localparam logic [VALUE_W-1:0] MAX_V =
    (longint'(MAXD) >= (longint'(1) << VALUE_W)) ? {VALUE_W{1'b1}} : VALUE_W'(MAXD);
  localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [VALUE_W-1:0]    value_clamped;
  logic                  pend_vld;
  logic [VALUE_W-1:0]    pend_val;
  logic                  launch;
  logic                  conv_start;
  logic [VALUE_W-1:0]    conv_bin;
  logic                  conv_done;
  logic [BCD_W-1:0]      bcd;
  logic [RC_W-1:0]       rcnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic [DIGIT_W-1:0]    sel_digit;
  logic                  sel_blank;

  assign value_clamped = (value > MAX_V) ? MAX_V : value;

  // launch is the cycle after a completion that had a queued request.
  assign conv_start = launch | (~busy & load);
  assign conv_bin   = launch ? pend_val : value_clamped;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      launch   <= 1'b0;
    end else begin
      launch <= 1'b0;
      if (!busy) begin
        if (load) busy <= 1'b1;
      end else begin
        if (launch) pend_vld <= 1'b0;
        if (load) begin
          pend_vld <= 1'b1;
          pend_val <= value_clamped;
        end
        if (conv_done) begin
          if (pend_vld || load) launch <= 1'b1;
          else                  busy   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RC_LAST) begin
      rcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      rcnt <= rcnt + RC_W'(1);
    end
  end

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    sel_digit  = '0;
    sel_blank  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (bcd[DIGIT_W*k +: DIGIT_W] == '0);
      blank[k]   = (BLANK_LZ != 0) && (k > 0) && zero_above;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_digit = bcd[DIGIT_W*k +: DIGIT_W];
        sel_blank = blank[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= ~NUM_DIGITS'(1);
      digit_code <= '0;
    end else begin
      an         <= ~(NUM_DIGITS'(1) << idx);
      digit_code <= sel_blank ? BLANK_CODE : sel_digit;
    end
  end

endmodule
